// File: rtl/std_fp_sqrt_pkg.sv
// Shared definitions for the iterative fixed-point square root:
// FSM state encoding and the iteration-count helper.
package std_fp_sqrt_pkg;

  // Controller states: wait for go, iterate, pulse done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of two-bit digit steps needed for a radicand of width+frac_width
  // bits, rounded up to an even width (one leading zero bit when odd).
  function automatic int sqrt_iterations(input int width, input int frac_width);
    return (width + frac_width + 1) / 2;
  endfunction

endpackage

// File: rtl/std_fp_sqrt_step.sv
// One combinational digit step of the restoring binary square root.
// Shifts the next radicand bit pair into the remainder, tries to subtract
// (root<<2)|1 and appends the resulting root bit.
module std_fp_sqrt_step #(
  parameter int ITERATIONS = 24
) (
  input  logic [ITERATIONS+1:0] rem,
  input  logic [ITERATIONS-1:0] root,
  input  logic [1:0]            pair,
  output logic [ITERATIONS+1:0] rem_next,
  output logic [ITERATIONS-1:0] root_next
);

  localparam int RW = ITERATIONS + 2;

  // The shifted remainder is kept two bits wider so the comparison never
  // loses the bits pushed out of rem; the final result always fits in RW.
  logic [RW+1:0] shifted;
  logic [RW+1:0] trial;
  logic [RW+1:0] diff;
  logic          fits;

  // Trial subtraction and root bit selection.
  always_comb begin
    shifted   = {rem, pair};
    trial     = {2'b00, root, 2'b01};
    fits      = (shifted >= trial);
    diff      = shifted - trial;
    rem_next  = fits ? RW'(diff) : RW'(shifted);
    root_next = {root[ITERATIONS-2:0], fits};
  end

endmodule

// File: rtl/std_fp_sqrt_pipe.sv
// Iterative unsigned fixed-point square root, one result bit per clock.
// The radicand is extended with FRAC_WIDTH zero bits so the root keeps the
// same binary point as the input. Optional feature: define
// STD_FP_SQRT_REMAINDER_EN to add out_remainder = X - out^2.
module std_fp_sqrt_pipe
  import std_fp_sqrt_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             done
`ifdef STD_FP_SQRT_REMAINDER_EN
  ,
  output logic [WIDTH:0]   out_remainder
`endif
);

  localparam int ITERATIONS = sqrt_iterations(WIDTH, FRAC_WIDTH);
  localparam int R          = 2 * ITERATIONS;
  localparam int RW         = ITERATIONS + 2;
  localparam int CNT_W      = $clog2(ITERATIONS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);

  // Reject inconsistent format parameters at elaboration.
  if ((INT_WIDTH + FRAC_WIDTH != WIDTH) || (FRAC_WIDTH > WIDTH)) begin : g_param_err
    $error("std_fp_sqrt_pipe: INT_WIDTH+FRAC_WIDTH must equal WIDTH and FRAC_WIDTH must not exceed WIDTH");
  end

  state_t state_reg, state_next;

  logic [R-1:0]      x_reg;
  logic [RW-1:0]     rem_reg;
  logic [ITERATIONS-1:0] root_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [WIDTH-1:0]  out_reg;
  logic              done_reg;

  logic              start;
  logic              step;
  logic              finish;

  logic [RW-1:0]     rem_next;
  logic [ITERATIONS-1:0] root_next;

  std_fp_sqrt_step #(
    .ITERATIONS(ITERATIONS)
  ) u_step (
    .rem       (rem_reg),
    .root      (root_reg),
    .pair      (x_reg[R-1 -: 2]),
    .rem_next  (rem_next),
    .root_next (root_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath control; go only matters in IDLE.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (go) begin
          start      = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_reg == LAST_CNT) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: latch radicand on start, iterate, capture the root on finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg    <= '0;
      rem_reg  <= '0;
      root_reg <= '0;
      cnt_reg  <= '0;
      out_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= finish;
      if (start) begin
        x_reg    <= R'(in) << FRAC_WIDTH;
        rem_reg  <= '0;
        root_reg <= '0;
        cnt_reg  <= '0;
        out_reg  <= '0;
      end else if (step) begin
        x_reg    <= x_reg << 2;
        rem_reg  <= rem_next;
        root_reg <= root_next;
        cnt_reg  <= cnt_reg + CNT_W'(1);
        if (finish) begin
          out_reg <= WIDTH'(root_next);
        end
      end
    end
  end

  assign out  = out_reg;
  assign done = done_reg;

`ifdef STD_FP_SQRT_REMAINDER_EN
  logic [WIDTH:0] rem_out_reg;

  // Final remainder follows the same clear/hold rules as out.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_out_reg <= '0;
    end else if (start) begin
      rem_out_reg <= '0;
    end else if (finish) begin
      rem_out_reg <= (WIDTH + 1)'(rem_next);
    end
  end

  assign out_remainder = rem_out_reg;
`endif

endmodule

// File: tb/tb_std_fp_sqrt_pipe.sv
// Self-checking bench for std_fp_sqrt_pipe (WIDTH=32, Q16.16).
// Expected results come from a binary-search integer square root model and
// are queued at start, then popped when done pulses.
module tb_std_fp_sqrt_pipe;

  localparam int WIDTH      = 32;
  localparam int INT_WIDTH  = 16;
  localparam int FRAC_WIDTH = 16;
  localparam int ITERS      = 24;

  typedef struct {
    logic [WIDTH-1:0] root;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] val;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             go;
  logic [WIDTH-1:0] in_sig;
  logic [WIDTH-1:0] out_sig;
  logic             done;
`ifdef STD_FP_SQRT_REMAINDER_EN
  logic [WIDTH:0]   rem_sig;
`endif

  int   pass_cnt;
  int   total_cnt;
  exp_t sb[$];

  std_fp_sqrt_pipe #(
    .WIDTH      (WIDTH),
    .INT_WIDTH  (INT_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .in    (in_sig),
    .out   (out_sig),
    .done  (done)
`ifdef STD_FP_SQRT_REMAINDER_EN
    ,
    .out_remainder (rem_sig)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: largest r with r*r <= X, found by binary search.
  function automatic exp_t model(input logic [WIDTH-1:0] v);
    longint unsigned x, lo, hi, mid;
    exp_t e;
    x  = longint'(v) << FRAC_WIDTH;
    lo = 0;
    hi = (64'd1 << ITERS) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    e.root = WIDTH'(lo);
    e.rem  = (WIDTH + 1)'(x - lo * lo);
    e.val  = v;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      $display("txn in=0x%08h out=0x%08h exp=0x%08h", e.val, out_sig, e.root);
      check({tag, "_out"}, 64'(out_sig), 64'(e.root));
`ifdef STD_FP_SQRT_REMAINDER_EN
      check({tag, "_rem"}, 64'(rem_sig), 64'(e.rem));
`endif
    end
  endtask

  // mode 0: plain op; 1: extra go pulse during RUN; 2: reset in cycle 10.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] val, input int mode);
    int   first_done;
    int   n_done;
    exp_t e;
    first_done = -1;
    n_done     = 0;
    e          = model(val);
    @(posedge clk); #1;
    go     = 1'b1;
    in_sig = val;
    sb.push_back(e);
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      go    = (mode == 1 && c == 10);
      reset = (mode == 2 && c == 10);
      if (mode == 2 && c == 10) void'(sb.pop_back());
      if (c < 24) in_sig = $urandom;
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = c;
        check_result(tag);
      end
      if (mode != 2 && c == 28) check({tag, "_hold"}, 64'(out_sig), 64'(e.root));
      if (mode == 2 && c == 30) check({tag, "_abort_out"}, 64'(out_sig), 64'd0);
    end
    go    = 1'b0;
    reset = 1'b0;
    if (mode == 2) begin
      check({tag, "_abort_ndone"}, 64'(n_done), 64'd0);
    end else begin
      check({tag, "_latency"}, 64'(first_done), 64'(ITERS + 1));
      check({tag, "_ndone"}, 64'(n_done), 64'd1);
    end
  endtask

  initial begin
    int   n_done;
    exp_t e9;
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    go        = 1'b0;
    in_sig    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_done", 64'(done), 64'd0);
    check("reset_out", 64'(out_sig), 64'd0);
`ifdef STD_FP_SQRT_REMAINDER_EN
    check("reset_rem", 64'(rem_sig), 64'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    do_op("four",  32'h0004_0000, 0);
    check("four_const", 64'(out_sig), 64'h0002_0000);
    do_op("two",   32'h0002_0000, 1);
    check("two_const", 64'(out_sig), 64'h0001_6A09);
    do_op("zero",  32'h0000_0000, 0);
    do_op("ones",  32'hFFFF_FFFF, 0);
    check("ones_const", 64'(out_sig), 64'h00FF_FFFF);
`ifdef STD_FP_SQRT_REMAINDER_EN
    check("ones_rem_const", 64'(rem_sig), 64'h1FE_FFFF);
`endif
    do_op("abort", 32'h0004_0000, 2);
    do_op("after_abort", 32'h0019_0000, 0);
    do_op("lsb",   32'h0000_0001, 0);
    for (int i = 0; i < 3; i++) do_op("rand", $urandom, 0);

    // go held high: back-to-back ops every 26 cycles, in toggled mid-RUN.
    e9     = model(32'h0009_0000);
    n_done = 0;
    @(posedge clk); #1;
    go     = 1'b1;
    in_sig = 32'h0009_0000;
    sb.push_back(e9);
    for (int c = 1; c <= 85; c++) begin
      int ph;
      @(posedge clk); #1;
      go     = (c <= 77);
      ph     = c % 26;
      in_sig = (ph >= 3 && ph <= 20) ? WIDTH'($urandom) : 32'h0009_0000;
      if (c == 26 || c == 52) sb.push_back(e9);
      @(negedge clk);
      if (done) begin
        check("held_cycle", 64'(c), 64'(25 + 26 * n_done));
        check_result("held");
        n_done++;
      end
      if (c == 30) check("held_cleared", 64'(out_sig), 64'd0);
    end
    go = 1'b0;
    check("held_ndone", 64'(n_done), 64'd3);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
